// File: rtl/seq_pkg.sv
// ---------------------------------------------------------------------------
// seq_pkg
// Types and constants shared by the serial sequence detector and its
// upstream bit feeder.
//   feed_state_t       : feeder FSM states (idle / shifting a word)
//   IDLE_LEVEL_DEFAULT : serial line level while no word is shifting
//   det_state_t        : detector FSM state encodings
// ---------------------------------------------------------------------------
package seq_pkg;

  typedef enum logic {
    FEED_IDLE  = 1'b0,
    FEED_SHIFT = 1'b1
  } feed_state_t;

  localparam logic IDLE_LEVEL_DEFAULT = 1'b0;

  typedef enum logic [1:0] {
    DET_S0 = 2'd0,
    DET_S1 = 2'd1,
    DET_S2 = 2'd2,
    DET_S3 = 2'd3
  } det_state_t;

endpackage

// File: rtl/bit_shift_reg.sv
// ---------------------------------------------------------------------------
// bit_shift_reg
// Parallel-load shift register presenting one bit at a time.
//   clk       : clock
//   load      : capture load_data (has priority over shift)
//   shift     : advance to the next bit
//   load_data : parallel word to serialize
//   bit_out   : current bit (MSB or LSB of the register per MSB_FIRST)
// Pure datapath: it carries no reset, the owner decides when the bit is
// meaningful.
// ---------------------------------------------------------------------------
module bit_shift_reg
  import seq_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] load_data,
  output logic             bit_out
);

  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] w_shifted;

  generate
    if (MSB_FIRST) begin : g_msb_first
      assign w_shifted = {r_data[WIDTH-2:0], 1'b0};
      assign bit_out   = r_data[WIDTH-1];
    end else begin : g_lsb_first
      assign w_shifted = {1'b0, r_data[WIDTH-1:1]};
      assign bit_out   = r_data[0];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (load) begin
      r_data <= load_data;
    end else if (shift) begin
      r_data <= w_shifted;
    end
  end

endmodule

// File: rtl/serial_bit_feeder.sv
// ---------------------------------------------------------------------------
// serial_bit_feeder
// Accepts parallel words on a valid/ready handshake and serializes them, one
// bit per enabled clock, onto the detector's serial input. A one-word hold
// register lets consecutive words run without a gap.
//   clk        : clock, all logic on posedge
//   reset_n    : synchronous reset, ACTIVE HIGH (1 = reset) despite the name
//   data_in    : parallel word, sampled on accept
//   data_valid : producer offers data_in
//   data_ready : a word can be accepted this cycle
//   enable     : bit-rate strobe; shifting advances only when high
//   serial_out : serial bit (IDLE_LEVEL when no word is shifting)
//   bit_valid  : serial_out carries a word bit
//   word_done  : one-cycle pulse after the last bit of a word is consumed
//   busy       : shifting or hold register full
// ---------------------------------------------------------------------------
module serial_bit_feeder
  import seq_pkg::*;
#(
  parameter int   WIDTH      = 8,
  parameter bit   MSB_FIRST  = 1'b1,
  parameter logic IDLE_LEVEL = IDLE_LEVEL_DEFAULT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  input  logic             enable,
  output logic             serial_out,
  output logic             bit_valid,
  output logic             word_done,
  output logic             busy
);

  localparam int             CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  feed_state_t      r_state;
  feed_state_t      w_state_next;
  logic [WIDTH-1:0] r_hold;
  logic             r_hold_full;
  logic             w_hold_full_next;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_next;
  logic             r_word_done;
  logic             w_word_done_next;
  logic             w_accept;
  logic             w_load;
  logic             w_shift;
  logic             w_bit;

  // Ready is withheld during reset so nothing is captured while the block
  // is being cleared, and while the hold register is occupied so an accept
  // and a drain can never coincide.
  assign w_accept = data_valid && !r_hold_full && !reset_n;

  bit_shift_reg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shift (
    .clk       (clk),
    .load      (w_load),
    .shift     (w_shift),
    .load_data (r_hold),
    .bit_out   (w_bit)
  );

  // Hold register is pure data; its occupancy lives in r_hold_full.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_hold <= data_in;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset_n) begin
      r_state     <= FEED_IDLE;
      r_hold_full <= 1'b0;
      r_count     <= '0;
      r_word_done <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_hold_full <= w_hold_full_next;
      r_count     <= w_count_next;
      r_word_done <= w_word_done_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next     = r_state;
    w_hold_full_next = r_hold_full;
    w_count_next     = r_count;
    w_word_done_next = 1'b0;
    w_load           = 1'b0;
    w_shift          = 1'b0;

    if (w_accept) begin
      w_hold_full_next = 1'b1;
    end

    case (r_state)
      FEED_IDLE: begin
        // Starting a word does not wait for the bit strobe.
        if (r_hold_full) begin
          w_load           = 1'b1;
          w_hold_full_next = 1'b0;
          w_count_next     = '0;
          w_state_next     = FEED_SHIFT;
        end
      end
      FEED_SHIFT: begin
        if (enable) begin
          if (r_count != LAST_CNT) begin
            w_shift      = 1'b1;
            w_count_next = r_count + CNT_W'(1);
          end else begin
            w_word_done_next = 1'b1;
            // Chain straight into the buffered word for a gap-free stream.
            if (r_hold_full) begin
              w_load           = 1'b1;
              w_hold_full_next = 1'b0;
              w_count_next     = '0;
            end else begin
              w_state_next = FEED_IDLE;
            end
          end
        end
      end
      default: w_state_next = FEED_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    data_ready = !r_hold_full && !reset_n;
    bit_valid  = (r_state == FEED_SHIFT);
    serial_out = (r_state == FEED_SHIFT) ? w_bit : IDLE_LEVEL;
    word_done  = r_word_done;
    busy       = (r_state == FEED_SHIFT) || r_hold_full;
  end

endmodule

// File: tb/tb_serial_bit_feeder.sv
module tb_serial_bit_feeder;

  localparam int W = 8;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       enable;
  logic [7:0] data_in, data_in2;
  logic       data_valid, data_valid2;
  logic       data_ready, data_ready2;
  logic       serial_out, serial_out2;
  logic       bit_valid, bit_valid2;
  logic       word_done, word_done2;
  logic       busy, busy2;

  always #5 clk = ~clk;

  serial_bit_feeder #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut_msb (
    .clk(clk), .reset_n(reset_n), .data_in(data_in), .data_valid(data_valid),
    .data_ready(data_ready), .enable(enable), .serial_out(serial_out),
    .bit_valid(bit_valid), .word_done(word_done), .busy(busy)
  );

  serial_bit_feeder #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut_lsb (
    .clk(clk), .reset_n(reset_n), .data_in(data_in2), .data_valid(data_valid2),
    .data_ready(data_ready2), .enable(enable), .serial_out(serial_out2),
    .bit_valid(bit_valid2), .word_done(word_done2), .busy(busy2)
  );

  typedef struct {
    string       name;
    logic [7:0]  w0;
    logic [7:0]  w1;
    int          nwords;
    bit          alt;
    bit          lsb;
    logic [15:0] stream;       // expected serial bits, first bit at [15]
    int          exp_bv;       // cycles with bit_valid high
    int          exp_done_off; // first word_done minus first-bit cycle
  } vec_t;

  vec_t vecs[4];

  int errors = 0;
  int checks = 0;

  // bench-side state shared by tick() and the tests
  int          cyc = 0;
  bit          en_alt = 1'b0;
  int          en_ref = 0;
  bit          sel_lsb = 1'b0;
  logic        rst_next = 1'b1;
  logic [7:0]  pend_q[$];
  bit          exp_q[$];
  logic [15:0] cur_stream;
  int          push_idx;
  int          acc_cyc[$];
  int          done_cyc[$];
  int          first_bv, last_bv, bv_cnt, consumed;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clear_tracking();
    exp_q.delete();
    acc_cyc.delete();
    done_cyc.delete();
    pend_q.delete();
    first_bv = -1;
    last_bv  = -1;
    bv_cnt   = 0;
    consumed = 0;
    push_idx = 0;
  endtask

  // One clock: drive inputs for the next edge, score the bit that edge
  // consumes, and act as producer for the pending-word queue.
  task automatic tick();
    logic s_out, s_bv, s_wd, s_rdy;
    @(negedge clk);
    cyc++;
    reset_n = rst_next;
    enable  = en_alt ? (((cyc - en_ref) & 1) != 0) : 1'b1;
    #1;
    s_out = sel_lsb ? serial_out2 : serial_out;
    s_bv  = sel_lsb ? bit_valid2  : bit_valid;
    s_wd  = sel_lsb ? word_done2  : word_done;
    s_rdy = sel_lsb ? data_ready2 : data_ready;
    if (s_bv) begin
      bv_cnt++;
      if (first_bv < 0) first_bv = cyc;
      last_bv = cyc;
      if (enable && !reset_n) begin
        consumed++;
        check("bit_expected", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) check("serial_bit", s_out, exp_q.pop_front());
      end
    end
    if (s_wd) done_cyc.push_back(cyc);
    data_valid  = 1'b0;
    data_valid2 = 1'b0;
    if (pend_q.size() > 0) begin
      if (sel_lsb) begin data_in2 = pend_q[0]; data_valid2 = 1'b1; end
      else         begin data_in  = pend_q[0]; data_valid  = 1'b1; end
      if (s_rdy) begin
        void'(pend_q.pop_front());
        if (push_idx < 2) begin
          for (int i = 0; i < W; i++) exp_q.push_back(cur_stream[15 - 8*push_idx - i]);
        end
        push_idx++;
        if (acc_cyc.size() == 0) en_ref = cyc;
        acc_cyc.push_back(cyc);
      end
    end
  endtask

  task automatic do_reset(input int n);
    rst_next = 1'b1;
    for (int i = 0; i < n; i++) tick();
    rst_next = 1'b0;
    tick();
  endtask

  task automatic run_vector(input vec_t v);
    int i;
    en_alt  = v.alt;
    sel_lsb = v.lsb;
    do_reset(2);
    clear_tracking();
    cur_stream = v.stream;
    pend_q.push_back(v.w0);
    if (v.nwords == 2) pend_q.push_back(v.w1);
    for (i = 0; i < 200; i++) begin
      tick();
      if (pend_q.size() == 0 && exp_q.size() == 0 && done_cyc.size() >= v.nwords) break;
    end
    check({v.name, "_timeout"}, i < 200, 1'b1);
    tick();
    tick();
    check({v.name, "_idle_busy"}, sel_lsb ? busy2 : busy, 1'b0);
    check({v.name, "_idle_out"}, sel_lsb ? serial_out2 : serial_out, 1'b0);
    check({v.name, "_idle_bv"}, sel_lsb ? bit_valid2 : bit_valid, 1'b0);
    check({v.name, "_accepts"}, acc_cyc.size(), v.nwords);
    check({v.name, "_done_count"}, done_cyc.size(), v.nwords);
    check({v.name, "_bv_cycles"}, bv_cnt, v.exp_bv);
    check({v.name, "_contiguous"}, last_bv - first_bv + 1, v.exp_bv);
    if (acc_cyc.size() == v.nwords && done_cyc.size() == v.nwords) begin
      check({v.name, "_latency"}, first_bv - acc_cyc[0], 2);
      check({v.name, "_done_off"}, done_cyc[0] - first_bv, v.exp_done_off);
      if (v.nwords == 2) begin
        check({v.name, "_accept_gap"}, acc_cyc[1] - acc_cyc[0], 2);
        check({v.name, "_done_gap"}, done_cyc[1] - done_cyc[0], 8);
      end
    end
    $display("vector %s: bits=%0d bv_cycles=%0d words_done=%0d", v.name, consumed, bv_cnt,
             done_cyc.size());
  endtask

  initial begin
    int snap_bv;
    int i;
    reset_n = 1'b1;
    enable = 1'b0;
    data_in = '0;
    data_in2 = '0;
    data_valid = 1'b0;
    data_valid2 = 1'b0;

    vecs[0] = '{name:"single_B4", w0:8'hB4, w1:8'h00, nwords:1, alt:1'b0, lsb:1'b0,
                stream:16'b10110100_00000000, exp_bv:8, exp_done_off:8};
    vecs[1] = '{name:"b2b_A5_3C", w0:8'hA5, w1:8'h3C, nwords:2, alt:1'b0, lsb:1'b0,
                stream:16'b10100101_00111100, exp_bv:16, exp_done_off:8};
    vecs[2] = '{name:"alt_en_C3", w0:8'hC3, w1:8'h00, nwords:1, alt:1'b1, lsb:1'b0,
                stream:16'b11000011_00000000, exp_bv:16, exp_done_off:16};
    vecs[3] = '{name:"lsb_01", w0:8'h01, w1:8'h00, nwords:1, alt:1'b0, lsb:1'b1,
                stream:16'b10000000_00000000, exp_bv:8, exp_done_off:8};

    // Reset held with data offered: nothing accepted, outputs quiet.
    en_alt = 1'b0;
    sel_lsb = 1'b0;
    clear_tracking();
    cur_stream = 16'h5500;
    pend_q.push_back(8'h55);
    rst_next = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("rst_ready", data_ready, 1'b0);
      check("rst_out", serial_out, 1'b0);
      check("rst_bv", bit_valid, 1'b0);
      check("rst_done", word_done, 1'b0);
      check("rst_busy", busy, 1'b0);
    end
    pend_q.delete();
    rst_next = 1'b0;
    tick();
    check("rst_release_ready", data_ready, 1'b1);
    check("rst_nothing_held", busy, 1'b0);
    check("rst_no_accept", acc_cyc.size(), 0);
    $display("reset hold: ready=%0b busy=%0b after release", data_ready, busy);

    foreach (vecs[k]) run_vector(vecs[k]);

    // Reset mid-word with a second word buffered: both discarded.
    en_alt = 1'b0;
    sel_lsb = 1'b0;
    do_reset(1);
    clear_tracking();
    cur_stream = 16'hFF0F;
    pend_q.push_back(8'hFF);
    pend_q.push_back(8'h0F);
    for (i = 0; i < 50 && consumed < 3; i++) tick();
    check("mid_reach_3_bits", consumed, 3);
    check("mid_accepts", acc_cyc.size(), 2);
    rst_next = 1'b1;
    tick();
    rst_next = 1'b0;
    tick();
    check("mid_out", serial_out, 1'b0);
    check("mid_bv", bit_valid, 1'b0);
    check("mid_busy", busy, 1'b0);
    check("mid_done_pulse", word_done, 1'b0);
    exp_q.delete();
    snap_bv = bv_cnt;
    for (int k = 0; k < 20; k++) tick();
    check("mid_no_resume", bv_cnt - snap_bv, 0);
    check("mid_no_word_done", done_cyc.size(), 0);
    $display("mid-word reset: bits before reset=%0d, word_done pulses=%0d", consumed,
             done_cyc.size());

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/serial_bit_feeder.md
Name: serial_bit_feeder

Overview:
Upstream stage of the serial sequence detector. Accepts parallel words on a valid/ready handshake and serializes them into the single-bit stream that drives the detector's serial input, one bit per enabled clock. A one-word holding buffer lets back-to-back words form a gap-free bit stream. Marks valid bits and signals the end of each word.

Parameters:
WIDTH, 8, bits per word; must be >= 2
MSB_FIRST, 1, 1 = shift MSB first, 0 = LSB first
IDLE_LEVEL, 1'b0, level driven on serial_out when no word is being shifted

Ports:
clk  input  1  single clock, all logic on posedge
reset_n  input  1  synchronous, active-high reset: 1 = reset, 0 = run (codebase name, polarity as in detector)
data_in  input  WIDTH  parallel word, sampled on accept
data_valid  input  1  producer offers data_in
data_ready  output  1  block can accept a word this cycle
enable  input  1  bit-rate strobe; shift advances only on edges where enable=1
serial_out  output  1  serial bit to detector IN
bit_valid  output  1  serial_out carries a word bit
word_done  output  1  one-cycle pulse after last bit of a word is consumed
busy  output  1  shifting or holding-buffer full

Behaviour:
- Reset (reset_n=1 at posedge): state IDLE, hold_full=0, bit count=0, serial_out=IDLE_LEVEL, bit_valid=0, word_done=0. Output busy=0. data_ready=0 whenever reset_n=1. An in-flight word and a buffered word are discarded with no word_done.
- data_ready = !hold_full && !reset_n. Accept = data_valid && data_ready at a posedge. The accepted word goes into the hold register, and hold_full becomes 1.
- FSM states: IDLE, SHIFT.
- IDLE: if hold_full, then at the next posedge: shift_reg<=hold, hold_full<=0, count<=0, go to SHIFT. This move does not depend on enable. Otherwise remain in IDLE with serial_out=IDLE_LEVEL.
- SHIFT: serial_out is the current bit (MSB or LSB of shift_reg per MSB_FIRST). bit_valid=1.
  - Posedge with enable=1 and count<WIDTH-1: shift one position, count+1.
  - Posedge with enable=1 and count=WIDTH-1 (last bit): word_done=1 for the next cycle.
    - If hold_full: load next word, count=0, stay in SHIFT, hold_full<=0.
    - Otherwise: go to IDLE.
  - enable=0: shift_reg, count and serial_out hold. bit_valid stays 1.
- Latency: from accept edge E0, hold is full after E0; the first bit appears on serial_out after E1. Acceptance-to-first-bit is 2 cycles.
- Throughput: the hold register drains at the last-bit edge, and data_ready rises in the next cycle. The stream is contiguous if the producer responds within WIDTH-1 enabled bit times. A gap can only come from hold_full=0 at the last bit.
- A simultaneous accept and drain cannot occur, because data_ready=0 while hold_full=1.
- word_done: exactly one pulse per fully shifted word. It never fires for words killed by reset.
- busy = (state==SHIFT) || hold_full.

Decomposition:
- Shared package seq_pkg: state typedef (IDLE, SHIFT) and the default IDLE_LEVEL constant. The detector's state encodings also move here.
- One sub-module: bit_shift_reg. Its ports are load, shift, load_data and serial bit out. It is parameterized by WIDTH and MSB_FIRST.
- The FSM, hold register and counter stay in the top module.

Test Plan:
- Reset: reset_n=1 for 3 cycles with data_valid=1 -> serial_out=0, bit_valid=0, data_ready=0, word_done=0, nothing accepted; after release data_ready=1 next cycle.
- Single word 8'hB4, MSB_FIRST=1, enable=1 -> bit_valid high for 8 cycles starting 2 cycles after accept, serial_out 1,0,1,1,0,1,0,0, then one word_done pulse, then serial_out=0 and busy=0.
- Back-to-back 8'hA5 then 8'h3C, data_valid held high -> 16 contiguous bit_valid cycles with stream 10100101 00111100, two word_done pulses 8 cycles apart, data_ready low while hold_full.
- enable alternating 1,0 with word 8'hC3 -> each bit held 2 cycles, bit sequence unchanged, word_done 16 cycles after first bit.
- Reset_n=1 pulse after 3 bits of 8'hFF with 8'h0F buffered -> next cycle serial_out=0, bit_valid=0, busy=0; no word_done; neither word resumes after release.
- MSB_FIRST=0, word 8'h01 -> serial_out 1 then seven 0s.
